// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and width helpers for the single-clock FIFO.
// The count width is one bit wider than the address, so DEPTH itself is representable.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 41;
  localparam int DEF_ADDR_WIDTH = 4;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage: one write port, one read address.
// SYNC_FIFO_FWFT_EN selects a combinational read; otherwise the read is registered on rd_en.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset; only the control state defines validity.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_ctrl;
  assign unused_ctrl = rst_n ^ rd_en;
  assign rd_data = mem[rd_addr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller: pointers, count, levels, sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rd_en,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  input  logic [count_width(ADDR_WIDTH)-1:0]   af_level,
  input  logic [count_width(ADDR_WIDTH)-1:0]   ae_level,
  output logic [count_width(ADDR_WIDTH)-1:0]   count,
  output logic                                 overflow,
  output logic                                 underflow,
  input  logic                                 clr_err
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_level);
  assign almost_empty = (count <= ae_level);

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A new rejected request outranks a coincident clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full & ~flush) | (overflow & ~clr_err);
      underflow <= (rd_en & empty & ~flush) | (underflow & ~clr_err);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem_rd_data;
`else
  // flush never coincides with rd_acc, so this also clears rd_valid on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_acc;
  end
  assign rd_data = mem_rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl.
// Expectations follow SYNC_FIFO_FWFT_EN when it is defined for the build.
module tb_sync_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_en, rd_en, clr_err;
  logic [40:0] wr_data, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  af_level, ae_level, count;

  int total = 0;
  int bad   = 0;
  logic [40:0] q[$];
  logic [40:0] exp_word;

  always #5 clk = ~clk;

  sync_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .af_level(af_level),
    .ae_level(ae_level), .count(count), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push(input logic [40:0] d);
    wr_en = 1'b1; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pop(input logic [40:0] exp, input string tag);
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
`else
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
`endif
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0; wr_data = '0; af_level = 5'd12; ae_level = 5'd3;
    repeat (2) cyc();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 16; i++) begin
      push(41'(i));
      if (i == 2)  chk("fill_ae_at3", almost_empty, 1);
      if (i == 3)  chk("fill_ae_at4", almost_empty, 0);
      if (i == 10) chk("fill_af_at11", almost_full, 0);
      if (i == 11) chk("fill_af_at12", almost_full, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_empty", empty, 0);

    push(41'h99);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    clear_errors();
    chk("ovf_clr", overflow, 0);

    for (int i = 0; i < 16; i++) begin
      pop(41'(i), "drain_data");
      if (i == 11) chk("drain_ae_at4", almost_empty, 0);
      if (i == 12) chk("drain_ae_at3", almost_empty, 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    cyc();
`ifdef SYNC_FIFO_FWFT_EN
    chk("empty_data_zero", rd_data, 0);
`else
    chk("hold_data", rd_data, 41'hf);
`endif
    chk("valid_pulse_end", rd_valid, 0);

    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("unf_set", underflow, 1);
    chk("unf_valid", rd_valid, 0);
    clear_errors();
    chk("unf_clr", underflow, 0);

    for (int i = 0; i < 16; i++) push(41'h100 + 41'(i));
    chk("refill_full", full, 1);
    wr_en = 1'b1; wr_data = 41'h1ff; rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk("fullboth_data", rd_data, 41'h100);
    cyc();
`else
    cyc();
    chk("fullboth_data", rd_data, 41'h100);
    chk("fullboth_valid", rd_valid, 1);
`endif
    idle();
    chk("fullboth_count", count, 15);
    chk("fullboth_ovf", overflow, 1);
    clear_errors();

    for (int i = 1; i < 16; i++) pop(41'h100 + 41'(i), "drain2_data");
    chk("drain2_empty", empty, 1);
    wr_en = 1'b1; wr_data = 41'h200; rd_en = 1'b1;
    cyc();
    idle();
    chk("emptyboth_count", count, 1);
    chk("emptyboth_unf", underflow, 1);
    clear_errors();

    q.push_back(41'h200);
    for (int i = 1; i < 8; i++) begin
      push(41'h200 + 41'(i));
      q.push_back(41'h200 + 41'(i));
    end
    chk("wrap_start_count", count, 8);
    for (int i = 0; i < 40; i++) begin
      exp_word = q.pop_front();
      wr_en = 1'b1; wr_data = 41'h300 + 41'(i); rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_data", rd_data, exp_word);
      cyc();
`else
      cyc();
      chk("wrap_data", rd_data, exp_word);
`endif
      q.push_back(41'h300 + 41'(i));
    end
    idle();
    chk("wrap_count", count, 8);

    push(41'h400);
    chk("preflush_count", count, 9);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 41'h401;
    cyc();
    idle();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_unf", underflow, 0);
    chk("flush_valid", rd_valid, 0);

    rd_en = 1'b1; clr_err = 1'b1;
    cyc();
    idle();
    chk("set_wins", underflow, 1);
    clear_errors();
    chk("set_cleared", underflow, 0);

    af_level = 5'd0;
    #1;
    chk("af_zero", almost_full, 1);
    for (int i = 0; i < 3; i++) push(41'h500 + 41'(i));
    ae_level = 5'd16; af_level = 5'd4;
    #1;
    chk("ae_depth", almost_empty, 1);
    chk("af_below", almost_full, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    rst_n = 1'b1;
    cyc();
    push(41'h155);
    pop(41'h155, "post_rst_data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
